riscv_id_ex_reg: RTL and testbench

RISCV_ID_EX_REG -- requirements
Module: riscv_id_ex_reg

---
 rtl/riscv_id_ex_reg.sv | 136 +++++++++++++
 tb/tb_riscv_id_ex_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_id_ex_reg.sv
// rtl/riscv_id_ex_reg.sv - ID/EX pipeline slot with load-use bubble and MEM/WB operand forwarding
`ifndef ALU_OP_LEN
`define ALU_OP_LEN 4
`endif

module riscv_id_ex_reg #(
  parameter int XLEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [XLEN-1:0]        id_pc,
  input  logic [XLEN-1:0]        id_rs1_data,
  input  logic [XLEN-1:0]        id_rs2_data,
  input  logic [XLEN-1:0]        id_imm,
  input  logic [4:0]             id_rs1_addr,
  input  logic [4:0]             id_rs2_addr,
  input  logic [4:0]             id_rd_addr,
  input  logic [`ALU_OP_LEN-1:0] id_alu_op,
  input  logic                   id_src1_pc,
  input  logic                   id_src2_imm,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   id_mem_write,
  input  logic                   ex_stall,
  input  logic                   flush,
  input  logic                   mem_fwd_valid,
  input  logic [4:0]             mem_fwd_rd,
  input  logic [XLEN-1:0]        mem_fwd_data,
  input  logic                   wb_fwd_valid,
  input  logic [4:0]             wb_fwd_rd,
  input  logic [XLEN-1:0]        wb_fwd_data,
  output logic                   id_stall,
  output logic                   ex_valid,
  output logic                   ex_reg_write,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic [4:0]             ex_rd_addr,
  output logic [`ALU_OP_LEN-1:0] ex_alu_op,
  output logic [XLEN-1:0]        ex_pc,
  output logic [XLEN-1:0]        operand_1,
  output logic [XLEN-1:0]        operand_2,
  output logic [XLEN-1:0]        ex_store_data
);

  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1_addr;
  logic [4:0]      ex_rs2_addr;
  logic            ex_src1_pc;
  logic            ex_src2_imm;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            load_use;

  // MEM is younger than WB, so it wins when both target the same register
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    if (ex_rs1_addr == 5'd0)
      fwd_rs1 = '0;
    else if (mem_fwd_valid && mem_fwd_rd == ex_rs1_addr)
      fwd_rs1 = mem_fwd_data;
    else if (wb_fwd_valid && wb_fwd_rd == ex_rs1_addr)
      fwd_rs1 = wb_fwd_data;
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data;
    if (ex_rs2_addr == 5'd0)
      fwd_rs2 = '0;
    else if (mem_fwd_valid && mem_fwd_rd == ex_rs2_addr)
      fwd_rs2 = mem_fwd_data;
    else if (wb_fwd_valid && wb_fwd_rd == ex_rs2_addr)
      fwd_rs2 = wb_fwd_data;
  end

  assign load_use = ex_valid && ex_mem_read && (ex_rd_addr != 5'd0) && id_valid &&
                    ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));

  assign id_stall = !rst && !flush && (load_use || ex_stall);

  assign operand_1     = ex_src1_pc  ? ex_pc  : fwd_rs1;
  assign operand_2     = ex_src2_imm ? ex_imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_rd_addr   <= '0;
      ex_alu_op    <= '0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_src1_pc   <= 1'b0;
      ex_src2_imm  <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (ex_stall) begin
      // forwarding sources move on while we wait, so capture what they provide now
      ex_rs1_data <= fwd_rs1;
      ex_rs2_data <= fwd_rs2;
    end else if (load_use) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_rd_addr   <= '0;
    end else begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_valid && id_reg_write;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_mem_write <= id_valid && id_mem_write;
      ex_rd_addr   <= id_rd_addr;
      ex_alu_op    <= id_alu_op;
      ex_pc        <= id_pc;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= id_imm;
      ex_rs1_addr  <= id_rs1_addr;
      ex_rs2_addr  <= id_rs2_addr;
      ex_src1_pc   <= id_src1_pc;
      ex_src2_imm  <= id_src2_imm;
    end
  end

endmodule

// File: tb/tb_riscv_id_ex_reg.sv
// tb/tb_riscv_id_ex_reg.sv - directed bench for the ID/EX slot
`ifndef ALU_OP_LEN
`define ALU_OP_LEN 4
`endif

module tb_riscv_id_ex_reg;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [`ALU_OP_LEN-1:0] id_alu_op;
  logic id_src1_pc, id_src2_imm, id_reg_write, id_mem_read, id_mem_write;
  logic ex_stall, flush;
  logic mem_fwd_valid, wb_fwd_valid;
  logic [4:0] mem_fwd_rd, wb_fwd_rd;
  logic [XLEN-1:0] mem_fwd_data, wb_fwd_data;
  logic id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0] ex_rd_addr;
  logic [`ALU_OP_LEN-1:0] ex_alu_op;
  logic [XLEN-1:0] ex_pc, operand_1, operand_2, ex_store_data;

  int passed = 0;
  int total = 0;

  riscv_id_ex_reg #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_op(id_alu_op), .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_stall(ex_stall), .flush(flush),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_rd_addr(ex_rd_addr),
    .ex_alu_op(ex_alu_op), .ex_pc(ex_pc), .operand_1(operand_1), .operand_2(operand_2),
    .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1a,
                        input logic [4:0] rs2a, input logic [4:0] rda, input logic [31:0] rs1d,
                        input logic [31:0] rs2d, input logic [31:0] imm, input logic s1pc,
                        input logic s2imm, input logic rw, input logic mr, input logic mw);
    id_valid = v; id_pc = pc; id_rs1_addr = rs1a; id_rs2_addr = rs2a; id_rd_addr = rda;
    id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm; id_src1_pc = s1pc;
    id_src2_imm = s2imm; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_alu_op = '0;
  endtask

  initial begin
    rst = 1'b1; ex_stall = 0; flush = 0;
    mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    set_id(1, 32'h100, 1, 2, 3, 5, 7, 0, 0, 0, 1, 0, 0);
    #2;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_id_stall", id_stall, 0);
    chk("rst_rd_addr", ex_rd_addr, 0);
    step(); step();
    rst = 1'b0;

    // add x3,x1,x2
    step();
    chk("add_op1", operand_1, 5);
    chk("add_op2", operand_2, 7);
    chk("add_valid", ex_valid, 1);
    chk("add_rd", ex_rd_addr, 3);
    chk("add_rw", ex_reg_write, 1);
    chk("add_store", ex_store_data, 7);

    // pc/immediate operand selects
    set_id(1, 32'h200, 1, 2, 4, 5, 7, 32'h44, 1, 1, 1, 0, 0);
    step();
    chk("sel_op1_pc", operand_1, 32'h200);
    chk("sel_op2_imm", operand_2, 32'h44);
    chk("sel_store", ex_store_data, 7);

    // forwarding priority on rs1=x3, rs2=x3
    set_id(1, 32'h300, 3, 3, 6, 32'h1, 32'h2, 0, 0, 0, 1, 0, 0);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_fwd_valid = 1; mem_fwd_rd = 3; mem_fwd_data = 32'h10;
    wb_fwd_valid = 1; wb_fwd_rd = 3; wb_fwd_data = 32'h20;
    #1;
    chk("fwd_mem_op1", operand_1, 32'h10);
    chk("fwd_mem_op2", operand_2, 32'h10);
    mem_fwd_valid = 0;
    #1;
    chk("fwd_wb_op1", operand_1, 32'h20);
    wb_fwd_valid = 0;
    #1;
    chk("fwd_none_op1", operand_1, 32'h1);
    chk("fwd_none_store", ex_store_data, 32'h2);
    mem_fwd_valid = 1; mem_fwd_rd = 3; mem_fwd_data = 32'h10;
    wb_fwd_rd = 5'd2;
    #1;
    chk("fwd_indep_op2", operand_2, 32'h10);

    // x0 is never forwarded and reads as zero
    set_id(1, 32'h400, 0, 0, 7, 32'h55, 32'h66, 0, 0, 0, 1, 0, 0);
    step();
    mem_fwd_rd = 0; wb_fwd_valid = 1; wb_fwd_rd = 0;
    #1;
    chk("x0_op1", operand_1, 0);
    chk("x0_op2", operand_2, 0);
    mem_fwd_valid = 0; wb_fwd_valid = 0;

    // load-use: lw x5 then consumer of x5 in rs2
    set_id(1, 32'h500, 1, 0, 5, 32'h8, 0, 32'h4, 0, 1, 1, 1, 0);
    step();
    chk("lw_in_ex", ex_mem_read, 1);
    set_id(1, 32'h504, 1, 5, 7, 32'h9, 32'h3, 0, 0, 0, 1, 0, 0);
    #1;
    chk("lu_id_stall", id_stall, 1);
    step();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_rw", ex_reg_write, 0);
    chk("lu_bubble_mr", ex_mem_read, 0);
    chk("lu_bubble_mw", ex_mem_write, 0);
    chk("lu_stall_clear", id_stall, 0);
    step();
    chk("lu_after_valid", ex_valid, 1);
    chk("lu_after_rd", ex_rd_addr, 7);

    // no load-use when the decode slot is empty
    set_id(1, 32'h508, 1, 0, 5, 32'h8, 0, 32'h4, 0, 1, 1, 1, 0);
    step();
    set_id(0, 32'h50c, 5, 5, 8, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("lu_idle_no_stall", id_stall, 0);

    // ex_stall for 3 cycles with a one-cycle WB forward of x4
    set_id(1, 32'h600, 4, 0, 8, 32'h11, 0, 0, 0, 0, 1, 0, 0);
    step();
    set_id(1, 32'h604, 1, 2, 9, 32'h1, 32'h2, 0, 0, 0, 1, 0, 0);
    ex_stall = 1; wb_fwd_valid = 1; wb_fwd_rd = 4; wb_fwd_data = 32'h99;
    #1;
    chk("stall_c1_op1", operand_1, 32'h99);
    chk("stall_id_stall", id_stall, 1);
    step();
    wb_fwd_valid = 0;
    #1;
    chk("stall_c2_op1", operand_1, 32'h99);
    chk("stall_c2_rd", ex_rd_addr, 8);
    step();
    chk("stall_c3_op1", operand_1, 32'h99);
    chk("stall_c3_pc", ex_pc, 32'h600);
    ex_stall = 0;

    // flush wins over ex_stall
    set_id(1, 32'h700, 1, 2, 0, 32'h1, 32'h2, 0, 0, 1, 0, 0, 1);
    step();
    chk("store_mw", ex_mem_write, 1);
    flush = 1; ex_stall = 1;
    #1;
    chk("flush_id_stall", id_stall, 0);
    step();
    chk("flush_valid", ex_valid, 0);
    chk("flush_mw", ex_mem_write, 0);
    flush = 0; ex_stall = 0;

    // asynchronous reset in the middle of a load-use stall
    set_id(1, 32'h800, 1, 0, 5, 32'h8, 0, 32'h4, 0, 1, 1, 1, 0);
    step();
    set_id(1, 32'h804, 5, 0, 10, 32'h77, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("rst_pre_stall", id_stall, 1);
    #1;
    rst = 1;
    #1;
    chk("rst_mid_valid", ex_valid, 0);
    chk("rst_mid_mr", ex_mem_read, 0);
    chk("rst_mid_rd", ex_rd_addr, 0);
    chk("rst_mid_op1", operand_1, 0);
    chk("rst_mid_id_stall", id_stall, 0);
    #1;
    rst = 0;
    step();
    chk("rst_after_valid", ex_valid, 1);
    chk("rst_after_rd", ex_rd_addr, 10);
    chk("rst_after_op1", operand_1, 32'h77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
